// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: shift-add MULT/MULTU sequencer that time-shares an external adder.
// Define MUL_SIGNED_EN for two's-complement MULT (adds NEG_* sign-fixup states).
module adder32bit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    assign {c_out, sum} = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c_in};
endmodule

module mul_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     add_x,
    output logic [WIDTH-1:0]     add_y,
    output logic                 add_cin,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [2:0] IDLE = 3'd0, ITER = 3'd1, DONE = 3'd2;
`ifdef MUL_SIGNED_EN
    localparam logic [2:0] NEG_A = 3'd3, NEG_B = 3'd4, NEG_LO = 3'd5, NEG_HI = 3'd6;
    localparam logic [2:0] FIRST = NEG_A, LAST = NEG_LO;
    logic rsign_q, rsign_d, cneg_q, cneg_d;
`else
    localparam logic [2:0] FIRST = ITER, LAST = DONE;
`endif
    logic [2:0]           state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    assign busy    = state_q != IDLE;
    assign done    = state_q == DONE;
    assign product = product_q;

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
`ifdef MUL_SIGNED_EN
        rsign_d = rsign_q;
        cneg_d  = cneg_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                state_d = FIRST;
                mcand_d = a;
                hi_d    = '0;
                lo_d    = b;
                cnt_d   = '0;
`ifdef MUL_SIGNED_EN
                rsign_d = a[WIDTH-1] ^ b[WIDTH-1];
`endif
            end
            ITER: begin
                add_x = lo_q[0] ? hi_q : '0;
                add_y = lo_q[0] ? mcand_q : '0;
                // carry-out shifts into hi[W-1], so the 2W-bit result stays exact
                {hi_d, lo_d} = {lo_q[0] & add_cout, lo_q[0] ? add_sum : hi_q, lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(WIDTH - 1)) ? LAST : ITER;
            end
            DONE: state_d = IDLE;
`ifdef MUL_SIGNED_EN
            NEG_A: begin
                state_d = NEG_B;
                if (mcand_q[WIDTH-1]) begin
                    add_x   = ~mcand_q;
                    add_cin = 1'b1;
                    mcand_d = add_sum;
                end
            end
            NEG_B: begin
                state_d = ITER;
                if (lo_q[WIDTH-1]) begin
                    add_x   = ~lo_q;
                    add_cin = 1'b1;
                    lo_d    = add_sum;
                end
            end
            NEG_LO: begin
                state_d = NEG_HI;
                if (rsign_q) begin
                    add_x   = ~lo_q;
                    add_cin = 1'b1;
                    lo_d    = add_sum;
                    cneg_d  = add_cout;
                end
            end
            NEG_HI: begin
                state_d = DONE;
                if (rsign_q) begin
                    add_x   = ~hi_q;
                    add_cin = cneg_q;
                    hi_d    = add_sum;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        product_d = (state_d == DONE && state_q != DONE) ? {hi_d, lo_d} : product_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
`ifdef MUL_SIGNED_EN
            rsign_q   <= 1'b0;
            cneg_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
`ifdef MUL_SIGNED_EN
            rsign_q   <= rsign_d;
            cneg_q    <= cneg_d;
`endif
        end
    end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed and random checks of mul_seq_ctrl against a cycle-count/product model.
// Honours MUL_SIGNED_EN to switch latency and expected products to signed MULT.
module tb_mul_seq_ctrl;
`ifdef MUL_SIGNED_EN
    localparam int LAT = 37;
    localparam logic [63:0] E_FF = 64'h0000_0000_0000_0001;
    localparam logic [63:0] E_M3 = 64'hFFFF_FFFF_FFFF_FFF1;
`else
    localparam int LAT = 33;
    localparam logic [63:0] E_FF = 64'hFFFF_FFFE_0000_0001;
    localparam logic [63:0] E_M3 = 64'h0000_0004_FFFF_FFF1;
`endif
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, add_cin, add_cout;
    logic [63:0] product;
    logic [31:0] add_x, add_y, add_sum;
    int          total = 0, passed = 0;

    mul_seq_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .product(product),
        .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );
    adder32bit #(.WIDTH(32)) u_add (
        .x(add_x), .y(add_y), .c_in(add_cin), .sum(add_sum), .c_out(add_cout)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
`ifdef MUL_SIGNED_EN
        return 64'(longint'($signed(x)) * longint'($signed(y)));
`else
        return {32'b0, x} * {32'b0, y};
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: k counts cycles since the accepted start (0 = idle); done on cycle LAT.
    int          k = 0;
    logic [63:0] m_prod = '0;
    logic [31:0] pa = '0, pb = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k      <= 0;
            m_prod <= '0;
        end else if (k == 0) begin
            if (start) begin
                k  <= 1;
                pa <= a;
                pb <= b;
            end
        end else if (k == LAT) k <= 0;
        else begin
            k <= k + 1;
            if (k == LAT - 1) m_prod <= ref_mul(pa, pb);
        end
    end

    always @(negedge clk) begin
        check("busy", 64'(busy), 64'(k != 0));
        check("done", 64'(done), 64'(k == LAT));
        check("product", product, m_prod);
        if (k == 0 || k == LAT) check("adder idle", {add_cin, add_x, add_y}, 64'd0);
    end

    task automatic do_start(input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~x;
        b = $urandom;
        check("busy after start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input int n0, input logic [63:0] exp, input string name);
        int n = n0;
        while (!done && n < LAT + 20) begin
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, 64'(n), 64'(LAT));
        check({name, " product"}, product, exp);
    endtask

    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic [63:0] exp, input string name);
        do_start(x, y);
        wait_done(1, exp, name);
    endtask

    initial begin
        logic [31:0] x, y;
        int dcnt;
        repeat (2) @(negedge clk);
        check("reset outputs", {busy, done, add_cin, 61'd0} | product, 64'd0);
        rst_n = 1'b1;
        do_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, "3x5");
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, E_FF, "ffxff");
        do_op(32'h0, 32'h1234_5678, 64'h0, "0x1234");
        do_op(32'hFFFF_FFFD, 32'd5, E_M3, "m3x5");
        do_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "min x min");
        do_start(32'd7, 32'd9);
        repeat (8) @(negedge clk);
        a = 32'd2;
        b = 32'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(10, 64'd63, "7x9 busy-start");
        dcnt = 0;
        repeat (2 * LAT) begin
            @(negedge clk);
            dcnt += int'(done);
        end
        check("dropped start no done", 64'(dcnt), 64'd0);
        do_start(32'd6, 32'd7);
        repeat (11) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy/done", {62'd0, busy, done}, 64'd0);
        check("abort product", product, 64'd0);
        check("abort adder", {add_cin, add_x, add_y}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'd2, 32'd4, 64'd8, "2x4 after reset");
        for (int i = 0; i < 1000; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 8 == 0) x = '0;
            if (i % 8 == 1) y = 32'hFFFF_FFFF;
            if (i % 8 == 2) x = 32'h8000_0000;
            if (i % 8 == 3) y = 32'h7FFF_FFFF;
            do_op(x, y, ref_mul(x, y), "rand");
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
